io_buf_ds_prbs_loopback: RTL and testbench

Parametrised multi-channel differential I/O loopback tester for bitstream/ICB bring-up. Each channel drives an `O_BUF_DS` from a registered pattern source and receives through an `I_BUF_DS` into a self-synchronising checker. The checker reports lock state and a saturating error count. The block replaces single-channel inverter loopback designs with per-channel PRBS7, clock-pattern and inverted-passthrough modes, plus error injection for board-level link qualification.

---
 rtl/io_buf_ds_prbs_loopback.sv | 199 +++++++++++++++++++
 tb/tb_io_buf_ds_prbs_loopback.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_buf_ds_prbs_loopback.sv
// Multi-channel differential loopback tester: per-channel PRBS7 / clock / inverted-passthrough
// generator driving the transmit pair, and a self-synchronising checker with lock and error count.
module io_buf_ds_prbs_loopback #(
    parameter int CHANNELS     = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic [1:0]                    mode,
    input  logic                          rx_en,
    input  logic                          inject_err,
    input  logic                          clear_err,
    input  logic [CHANNELS-1:0]           in_P,
    input  logic [CHANNELS-1:0]           in_N,
    output logic [CHANNELS-1:0]           out_P,
    output logic [CHANNELS-1:0]           out_N,
    output logic [CHANNELS-1:0]           lock,
    output logic [CHANNELS*CNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        M_PASS = 2'b00,
        M_PRBS = 2'b01,
        M_CLK  = 2'b10,
        M_RSVD = 2'b11
    } mode_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam logic [7:0]           LOCK_LAST   = 8'(LOCK_COUNT - 1);
    localparam logic [3:0]           UNLOCK_LAST = 4'(UNLOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

    mode_t mode_q;
    logic  restart;
    logic  active;
    logic  tx_vld_q;
    logic  rx_vld_q;
    logic  chk_en;
    logic  prbs_sel;

    assign restart  = ~run | (mode != mode_q);
    assign active   = ~restart;
    assign prbs_sel = (mode_q == M_PRBS);
    // Checker only sees real transmitted data once the tx and rx registers have both been loaded.
    assign chk_en   = active & rx_vld_q & ((mode_q == M_PRBS) | (mode_q == M_CLK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= M_PASS;
            tx_vld_q <= 1'b0;
            rx_vld_q <= 1'b0;
        end else begin
            mode_q   <= mode_t'(mode);
            tx_vld_q <= active;
            rx_vld_q <= active & tx_vld_q;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [6:0] SEED = 7'(c + 1);

        logic                 rx_bit;
        logic                 rx_q;
        logic                 tx_q, tx_d;
        logic [6:0]           lfsr_q, lfsr_d;
        logic                 clk_ph_q, clk_ph_d;
        logic [6:0]           hist_q;
        chk_state_t           state_q;
        logic                 lock_q;
        logic [2:0]           fill_q;
        logic [7:0]           match_q;
        logic [3:0]           miss_q;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 pred;
        logic                 hit;
        logic                 miss_evt;

        // Differential receiver: a non-complementary pair or a disabled receiver resolves to 0.
        assign rx_bit   = rx_en & in_P[c] & ~in_N[c];
        assign pred     = prbs_sel ? (hist_q[6] ^ hist_q[5]) : ~hist_q[0];
        assign hit      = (rx_q == pred);
        assign miss_evt = chk_en & (state_q == LOCKED) & ~hit;

        always_comb begin
            tx_d     = 1'b0;
            lfsr_d   = lfsr_q;
            clk_ph_d = clk_ph_q;
            if (restart) begin
                lfsr_d   = SEED;
                clk_ph_d = 1'b0;
            end else begin
                case (mode_q)
                    M_PASS: tx_d = ~rx_q ^ inject_err;
                    M_PRBS: begin
                        tx_d   = lfsr_q[6] ^ inject_err;
                        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                    end
                    M_CLK: begin
                        tx_d     = clk_ph_q ^ inject_err;
                        clk_ph_d = ~clk_ph_q;
                    end
                    default: tx_d = 1'b0;
                endcase
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            if (clear_err) begin
                cnt_d = '0;
            end else if (miss_evt && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rx_q     <= 1'b0;
                tx_q     <= 1'b0;
                lfsr_q   <= SEED;
                clk_ph_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                rx_q     <= rx_bit;
                tx_q     <= tx_d;
                lfsr_q   <= lfsr_d;
                clk_ph_q <= clk_ph_d;
                cnt_q    <= cnt_d;
            end
        end

        // Checker FSM: fill the history, count consecutive hits to lock, consecutive misses to unlock.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= SEARCH;
                lock_q  <= 1'b0;
                fill_q  <= '0;
                match_q <= '0;
                miss_q  <= '0;
                hist_q  <= '0;
            end else if (restart) begin
                state_q <= SEARCH;
                lock_q  <= 1'b0;
                fill_q  <= '0;
                match_q <= '0;
                miss_q  <= '0;
                hist_q  <= '0;
            end else if (chk_en) begin
                hist_q <= {hist_q[5:0], rx_q};
                case (state_q)
                    SEARCH: begin
                        if (fill_q != 3'd7) begin
                            fill_q <= fill_q + 3'd1;
                        end else if (!hit) begin
                            match_q <= '0;
                        end else if (match_q == LOCK_LAST) begin
                            match_q <= '0;
                            miss_q  <= '0;
                            state_q <= LOCKED;
                            lock_q  <= 1'b1;
                        end else begin
                            match_q <= match_q + 8'd1;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            miss_q <= '0;
                        end else if (miss_q == UNLOCK_LAST) begin
                            miss_q  <= '0;
                            fill_q  <= '0;
                            match_q <= '0;
                            state_q <= SEARCH;
                            lock_q  <= 1'b0;
                        end else begin
                            miss_q <= miss_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q <= SEARCH;
                        lock_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign out_P[c]                              = tx_q;
        assign out_N[c]                              = ~tx_q;
        assign lock[c]                               = lock_q;
        assign err_count[c*CNT_WIDTH +: CNT_WIDTH]   = cnt_q;
    end

endmodule

// File: tb/tb_io_buf_ds_prbs_loopback.sv
// Directed bench for io_buf_ds_prbs_loopback: a 4-channel instance looped back through the bench,
// plus a 1-channel 4-bit-counter instance for saturation and clear priority.
module tb_io_buf_ds_prbs_loopback;

    localparam int C  = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            run;
    logic [1:0]      mode;
    logic            rx_en;
    logic            inject_err;
    logic            clear_err;
    logic [C-1:0]    in_P, in_N, out_P, out_N, lock;
    logic [C*CW-1:0] err_count;

    logic            loop_pt;
    logic            force_en;
    logic            force_val;
    logic [C-1:0]    pt_drv;

    assign in_P = loop_pt ? pt_drv : (force_en ? {C{force_val}} : out_P);
    assign in_N = ~in_P;

    logic       s_run, s_inj, s_clr;
    logic [1:0] s_mode;
    logic [0:0] s_in_P, s_in_N, s_out_P, s_out_N, s_lock;
    logic [3:0] s_err;

    assign s_in_P = s_out_P;
    assign s_in_N = s_out_N;

    io_buf_ds_prbs_loopback #(
        .CHANNELS(C), .CNT_WIDTH(CW), .LOCK_COUNT(16), .UNLOCK_COUNT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .rx_en(rx_en),
        .inject_err(inject_err), .clear_err(clear_err),
        .in_P(in_P), .in_N(in_N), .out_P(out_P), .out_N(out_N),
        .lock(lock), .err_count(err_count)
    );

    io_buf_ds_prbs_loopback #(
        .CHANNELS(1), .CNT_WIDTH(4), .LOCK_COUNT(16), .UNLOCK_COUNT(15)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .run(s_run), .mode(s_mode), .rx_en(rx_en),
        .inject_err(s_inj), .clear_err(s_clr),
        .in_P(s_in_P), .in_N(s_in_N), .out_P(s_out_P), .out_N(s_out_N),
        .lock(s_lock), .err_count(s_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] seq;
        logic [3:0]  pat;
        int          n;

        rst_n = 1'b0; run = 1'b0; mode = 2'b01; rx_en = 1'b1;
        inject_err = 1'b0; clear_err = 1'b0;
        loop_pt = 1'b0; force_en = 1'b0; force_val = 1'b0; pt_drv = '0;
        s_run = 1'b1; s_mode = 2'b01; s_inj = 1'b0; s_clr = 1'b0;
        seq = '0;
        pat = 4'b1001;

        #2;
        chk("rst_out_P", out_P, 4'h0);
        chk("rst_out_N", out_N, 4'hF);
        chk("rst_lock", lock, 4'h0);
        chk("rst_err", err_count, 64'h0);
        chk("rst_s_err", s_err, 4'h0);

        @(negedge clk) rst_n = 1'b1;
        tick(3);

        // PRBS lock: exact lock time and the channel-0 bit sequence from seed 1
        run = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k < 14) seq = {seq[12:0], out_P[0]};
            if (k == 23) chk("prbs_lock_early", lock, 4'h0);
        end
        chk("prbs_lock_25", lock, 4'hF);
        chk("prbs_ch0_seq", seq, 14'b00000010000011);
        tick(1000);
        chk("prbs_err_zero", err_count, 64'h0);
        chk("prbs_still_locked", lock, 4'hF);

        // Single injected bit in PRBS7 -> 3 errors per channel
        inject_err = 1'b1;
        tick(1);
        inject_err = 1'b0;
        tick(12);
        chk("inj_prbs_err", err_count, {4{16'd3}});
        chk("inj_prbs_lock", lock, 4'hF);

        // Clock pattern: restart, relock, then one injected bit -> 2 more errors
        mode = 2'b10;
        tick(1);
        chk("clk_restart_drop", lock, 4'h0);
        tick(24);
        chk("clk_lock_early", lock, 4'h0);
        tick(1);
        chk("clk_lock", lock, 4'hF);
        inject_err = 1'b1;
        tick(1);
        inject_err = 1'b0;
        tick(8);
        chk("inj_clk_err", err_count, {4{16'd5}});
        chk("inj_clk_lock", lock, 4'hF);

        // Loop stuck at 1 in clock mode -> 4 consecutive misses drop lock
        force_val = 1'b1;
        force_en  = 1'b1;
        n = 0;
        while (lock !== 4'h0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("unlock_lock", lock, 4'h0);
        chk("unlock_err", err_count, {4{16'd9}});
        force_en = 1'b0;
        tick(22);
        chk("relock_early", lock, 4'h0);
        tick(1);
        chk("relock_23", lock, 4'hF);

        // Inverted passthrough: 1,0,0,1 in -> 0,1,1,0 out two clocks later
        mode    = 2'b00;
        loop_pt = 1'b1;
        pt_drv  = '0;
        tick(3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) chk("pt_out", out_P, {C{~pat[5-k]}});
            if (k < 4)  pt_drv = {C{pat[3-k]}};
        end
        chk("pt_lock", lock, 4'h0);
        chk("pt_err_hold", err_count, {4{16'd9}});

        // Mode change 00 -> 01 restarts and relocks
        loop_pt = 1'b0;
        mode    = 2'b01;
        tick(25);
        chk("m01_lock_early", lock, 4'h0);
        tick(1);
        chk("m01_lock", lock, 4'hF);

        // Saturation with a 4-bit counter under continuous injection
        chk("sat_pre_lock", s_lock, 1'b1);
        s_inj = 1'b1;
        n = 0;
        while (s_lock !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sat_unlock", s_lock, 1'b0);
        chk("sat_err15", s_err, 4'd15);
        tick(10);
        chk("sat_hold15", s_err, 4'd15);
        s_inj = 1'b0;
        n = 0;
        while (s_lock !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("sat_relock", s_lock, 1'b1);

        // clear_err on the same edge as a miss wins, later misses of the same flip still count
        s_inj = 1'b1;
        tick(1);
        s_inj = 1'b0;
        tick(1);
        s_clr = 1'b1;
        tick(1);
        s_clr = 1'b0;
        chk("clr_vs_miss", s_err, 4'd0);
        tick(7);
        chk("clr_after_tail", s_err, 4'd2);
        chk("clr_lock", s_lock, 1'b1);

        // Asynchronous reset mid-stream
        chk("pre_rst_err", err_count, {4{16'd9}});
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_P", out_P, 4'h0);
        chk("arst_out_N", out_N, 4'hF);
        chk("arst_lock", lock, 4'h0);
        chk("arst_err", err_count, 64'h0);
        chk("arst_s_err", s_err, 4'h0);
        @(negedge clk) rst_n = 1'b1;
        tick(26);
        chk("post_rst_lock", lock, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
